// File: rtl/apb_controller_if.sv
// rtl/apb_controller_if.sv - AHB-side request and APB-side bus signals of the AHB-to-APB bridge
interface apb_controller_if;
  logic        valid;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [2:0]  tempselx;
  logic [31:0] prdata;
  logic        pwrite;
  logic        penable;
  logic [2:0]  pselx;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        hreadyout;
  logic [31:0] hrdata;

  modport slave (
    input  valid, hwrite, haddr, hwdata, tempselx, prdata,
    output pwrite, penable, pselx, paddr, pwdata, hreadyout, hrdata
  );

  modport master (
    output valid, hwrite, haddr, hwdata, tempselx, prdata,
    input  pwrite, penable, pselx, paddr, pwdata, hreadyout, hrdata
  );
endinterface

// File: rtl/apb_controller.sv
// rtl/apb_controller.sv - AHB-to-APB bridge controller with configurable APB ENABLE wait cycles
module apb_controller #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic             hclk,
  input logic             hresetn,
  apb_controller_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, WWAIT, WSETUP, WENABLE, RSETUP, RENABLE
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [2:0]  sel_q;
  logic [31:0] rdata_q;
  logic        pwrite_q;
  logic        penable_q;
  logic [2:0]  pselx_q;
  logic [31:0] paddr_q;
  logic [31:0] pwdata_q;
  logic        hready_q;

  logic is_last;
  logic accept;

  assign is_last = ((state == WENABLE) || (state == RENABLE)) && (cnt == 4'd0);
  assign accept  = bus.valid && (bus.tempselx != 3'b000) && ((state == IDLE) || is_last);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      addr_q    <= 32'd0;
      sel_q     <= 3'b000;
      rdata_q   <= 32'd0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      pselx_q   <= 3'b000;
      paddr_q   <= 32'd0;
      pwdata_q  <= 32'd0;
      hready_q  <= 1'b1;
    end else begin
      if ((state == RENABLE) && (cnt == 4'd0))
        rdata_q <= bus.prdata;
      if (((state == WENABLE) || (state == RENABLE)) && (cnt != 4'd0)) begin
        cnt      <= cnt - 4'd1;
        hready_q <= (cnt == 4'd1);
      end

      if (accept) begin
        // A new transfer may start straight out of the final ENABLE cycle.
        addr_q    <= bus.haddr;
        sel_q     <= bus.tempselx;
        penable_q <= 1'b0;
        if (bus.hwrite) begin
          state    <= WWAIT;
          pselx_q  <= 3'b000;
          hready_q <= 1'b1;
        end else begin
          state    <= RSETUP;
          pselx_q  <= bus.tempselx;
          paddr_q  <= bus.haddr;
          pwrite_q <= 1'b0;
          hready_q <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: state <= IDLE;
          WWAIT: begin
            // Write data arrives in the AHB data phase, one cycle after the address.
            state     <= WSETUP;
            pwdata_q  <= bus.hwdata;
            pselx_q   <= sel_q;
            paddr_q   <= addr_q;
            pwrite_q  <= 1'b1;
            penable_q <= 1'b0;
            hready_q  <= 1'b0;
          end
          WSETUP, RSETUP: begin
            state     <= (state == WSETUP) ? WENABLE : RENABLE;
            cnt       <= WAIT_LD;
            penable_q <= 1'b1;
            hready_q  <= (WAIT_LD == 4'd0);
          end
          WENABLE, RENABLE: begin
            if (cnt == 4'd0) begin
              state     <= IDLE;
              pselx_q   <= 3'b000;
              penable_q <= 1'b0;
              hready_q  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.pwrite    = pwrite_q;
  assign bus.penable   = penable_q;
  assign bus.pselx     = pselx_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.hreadyout = hready_q;
  assign bus.hrdata    = ((state == RENABLE) && (cnt == 4'd0)) ? bus.prdata : rdata_q;
endmodule

// File: tb/tb_apb_controller.sv
// tb/tb_apb_controller.sv - randomized transfer-level model check of apb_controller at 0 and 2 wait cycles
module tb_apb_controller;
  localparam int W0 = 0;
  localparam int W1 = 2;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        valid = 1'b0;
  logic        hwrite = 1'b0;
  logic [31:0] haddr = 32'd0;
  logic [31:0] hwdata = 32'd0;
  logic [2:0]  tempselx = 3'b000;
  logic [31:0] prdata = 32'd0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 hclk = ~hclk;

  apb_controller_if if0 ();
  apb_controller_if if1 ();

  assign if0.valid = valid;    assign if1.valid = valid;
  assign if0.hwrite = hwrite;  assign if1.hwrite = hwrite;
  assign if0.haddr = haddr;    assign if1.haddr = haddr;
  assign if0.hwdata = hwdata;  assign if1.hwdata = hwdata;
  assign if0.tempselx = tempselx; assign if1.tempselx = tempselx;
  assign if0.prdata = prdata;  assign if1.prdata = prdata;

  apb_controller #(.WAIT_CYCLES(W0)) u_dut0 (.hclk(hclk), .hresetn(hresetn), .bus(if0));
  apb_controller #(.WAIT_CYCLES(W1)) u_dut1 (.hclk(hclk), .hresetn(hresetn), .bus(if1));

  // Transfer-level model: a transfer is a sequence of cycles indexed by k.
  typedef struct {
    logic        busy;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  sel;
    logic [31:0] wdata;
    int          k;
    logic [31:0] l_paddr;
    logic        l_pwrite;
    logic [31:0] l_pwdata;
    logic [31:0] l_hrdata;
  } mdl_t;

  typedef struct {
    logic [2:0]  sel;
    logic        en;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    logic [31:0] rdata;
  } out_t;

  mdl_t mdl [2];

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.busy = 1'b0; m.wr = 1'b0; m.addr = 32'd0; m.sel = 3'b000; m.wdata = 32'd0; m.k = 0;
    m.l_paddr = 32'd0; m.l_pwrite = 1'b0; m.l_pwdata = 32'd0; m.l_hrdata = 32'd0;
    return m;
  endfunction

  function automatic int xfer_len(mdl_t m, int w);
    return m.wr ? (w + 3) : (w + 2);
  endfunction

  function automatic out_t model_out(mdl_t m, int w, logic [31:0] prd);
    out_t e;
    int setup_k;
    e.sel = 3'b000; e.en = 1'b0; e.wr = m.l_pwrite; e.addr = m.l_paddr;
    e.wdata = m.l_pwdata; e.rdy = 1'b1; e.rdata = m.l_hrdata;
    if (m.busy) begin
      setup_k = m.wr ? 1 : 0;
      if (m.k >= setup_k) begin
        e.sel = m.sel; e.addr = m.addr; e.wr = m.wr;
        if (m.wr) e.wdata = m.wdata;
      end
      if (m.k == setup_k) e.rdy = 1'b0;
      if (m.k > setup_k) begin
        e.en = 1'b1;
        e.rdy = (m.k == xfer_len(m, w) - 1);
        if (!m.wr && e.rdy) e.rdata = prd;
      end
    end
    return e;
  endfunction

  function automatic mdl_t model_step(mdl_t m, int w, logic v, logic hw, logic [31:0] ha,
                                      logic [31:0] hd, logic [2:0] sel, logic [31:0] prd);
    logic last;
    last = m.busy && (m.k == xfer_len(m, w) - 1);
    if (m.busy && m.wr && m.k == 0) m.wdata = hd;
    if (m.busy && m.k == (m.wr ? 1 : 0)) begin
      m.l_paddr = m.addr;
      m.l_pwrite = m.wr;
      if (m.wr) m.l_pwdata = m.wdata;
    end
    if (last && !m.wr) m.l_hrdata = prd;
    if ((!m.busy || last) && v && (sel != 3'b000)) begin
      m.busy = 1'b1; m.k = 0; m.wr = hw; m.addr = ha; m.sel = sel;
    end else if (last) begin
      m.busy = 1'b0;
    end else if (m.busy) begin
      m.k = m.k + 1;
    end
    return m;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(string p, out_t e, logic [2:0] sel, logic en, logic wr,
                          logic [31:0] addr, logic [31:0] wdata, logic rdy, logic [31:0] rdata);
    chk({p, ".pselx"}, 32'(sel), 32'(e.sel));
    chk({p, ".penable"}, 32'(en), 32'(e.en));
    chk({p, ".pwrite"}, 32'(wr), 32'(e.wr));
    chk({p, ".paddr"}, addr, e.addr);
    chk({p, ".pwdata"}, wdata, e.wdata);
    chk({p, ".hreadyout"}, 32'(rdy), 32'(e.rdy));
    chk({p, ".hrdata"}, rdata, e.rdata);
  endtask

  initial begin
    mdl[0] = mdl_reset();
    mdl[1] = mdl_reset();
    forever begin
      @(negedge hclk);
      if (!hresetn) begin
        mdl[0] = mdl_reset();
        mdl[1] = mdl_reset();
      end
      cmp_inst("w0", model_out(mdl[0], W0, prdata), if0.pselx, if0.penable, if0.pwrite,
               if0.paddr, if0.pwdata, if0.hreadyout, if0.hrdata);
      cmp_inst("w2", model_out(mdl[1], W1, prdata), if1.pselx, if1.penable, if1.pwrite,
               if1.paddr, if1.pwdata, if1.hreadyout, if1.hrdata);
      if (hresetn) begin
        mdl[0] = model_step(mdl[0], W0, valid, hwrite, haddr, hwdata, tempselx, prdata);
        mdl[1] = model_step(mdl[1], W1, valid, hwrite, haddr, hwdata, tempselx, prdata);
      end
    end
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  initial begin
    repeat (2) tick();
    @(negedge hclk);
    chk("lit.reset_pselx", 32'(if0.pselx), 32'd0);
    chk("lit.reset_hready", 32'(if0.hreadyout), 32'd1);
    chk("lit.reset_paddr", if0.paddr, 32'd0);
    chk("lit.reset_hrdata", if0.hrdata, 32'd0);

    tick();
    hresetn = 1'b1; valid = 1'b1; hwrite = 1'b0; haddr = 32'h8000_0010;
    tempselx = 3'b001; prdata = 32'h19;
    tick();
    valid = 1'b0;
    @(negedge hclk);
    chk("lit.rsetup_psel", 32'(if0.pselx), 32'd1);
    chk("lit.rsetup_penable", 32'(if0.penable), 32'd0);
    chk("lit.rsetup_hready", 32'(if0.hreadyout), 32'd0);
    tick();
    @(negedge hclk);
    chk("lit.renable_penable", 32'(if0.penable), 32'd1);
    chk("lit.renable_hready", 32'(if0.hreadyout), 32'd1);
    chk("lit.renable_hrdata", if0.hrdata, 32'h19);
    chk("lit.w2_en1_hready", 32'(if1.hreadyout), 32'd0);
    tick();
    @(negedge hclk);
    chk("lit.w2_en2_hready", 32'(if1.hreadyout), 32'd0);
    chk("lit.w2_en2_penable", 32'(if1.penable), 32'd1);
    tick();
    @(negedge hclk);
    chk("lit.w2_en3_hready", 32'(if1.hreadyout), 32'd1);
    chk("lit.w2_en3_hrdata", if1.hrdata, 32'h19);

    tick();
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8400_0004; tempselx = 3'b010;
    tick();
    valid = 1'b0; hwdata = 32'hDEAD_BEEF;
    @(negedge hclk);
    chk("lit.wwait_psel", 32'(if0.pselx), 32'd0);
    chk("lit.wwait_hready", 32'(if0.hreadyout), 32'd1);
    tick();
    @(negedge hclk);
    chk("lit.wsetup_pwrite", 32'(if0.pwrite), 32'd1);
    chk("lit.wsetup_paddr", if0.paddr, 32'h8400_0004);
    chk("lit.wsetup_pwdata", if0.pwdata, 32'hDEAD_BEEF);
    chk("lit.wsetup_hready", 32'(if0.hreadyout), 32'd0);
    tick();
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h8000_0020; tempselx = 3'b100; prdata = 32'h55;
    @(negedge hclk);
    chk("lit.wenable_penable", 32'(if0.penable), 32'd1);
    chk("lit.wenable_hready", 32'(if0.hreadyout), 32'd1);
    tick();
    valid = 1'b0;
    @(negedge hclk);
    chk("lit.b2b_rsetup_psel", 32'(if0.pselx), 32'd4);
    chk("lit.b2b_rsetup_paddr", if0.paddr, 32'h8000_0020);
    chk("lit.b2b_rsetup_penable", 32'(if0.penable), 32'd0);
    repeat (3) tick();

    valid = 1'b1; tempselx = 3'b000; hwrite = 1'b1;
    tick();
    valid = 1'b0;
    @(negedge hclk);
    chk("lit.nosel_psel", 32'(if0.pselx), 32'd0);
    chk("lit.nosel_hready", 32'(if0.hreadyout), 32'd1);

    tick();
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8800_0008; tempselx = 3'b001;
    tick();
    valid = 1'b0; hwdata = 32'h1234_5678;
    repeat (2) tick();
    hresetn = 1'b0;
    @(negedge hclk);
    chk("lit.rst_mid_penable", 32'(if0.penable), 32'd0);
    chk("lit.rst_mid_pwdata", if0.pwdata, 32'd0);
    chk("lit.rst_mid_hready", 32'(if0.hreadyout), 32'd1);
    tick();
    hresetn = 1'b1;
    @(negedge hclk);
    chk("lit.rst_after_psel", 32'(if0.pselx), 32'd0);

    for (int i = 0; i < 4000; i++) begin
      tick();
      hresetn = ($urandom_range(0, 249) != 0);
      valid = ($urandom_range(0, 9) < 7);
      hwrite = 1'($urandom_range(0, 1));
      haddr = $urandom;
      hwdata = $urandom;
      prdata = $urandom;
      case ($urandom_range(0, 4))
        0: tempselx = 3'b000;
        1: tempselx = 3'b001;
        2: tempselx = 3'b010;
        3: tempselx = 3'b100;
        default: tempselx = 3'b001;
      endcase
    end
    tick();
    hresetn = 1'b1;
    valid = 1'b0;
    @(negedge hclk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
